pixel_row_feeder: RTL and testbench

- Upstream stage of imageProcessTop: fetches an 8-bit grayscale frame from a synchronous-read pixel RAM and streams it into the filter's slave interface, row by row, in row-major order.
- Primes the filter with PRIME_LINES rows, then releases one further row per rising edge of the filter's o_intr.
- Ends the frame with PAD_LINES rows of zero pixels so the filter flushes its final output rows.
- Replaces bench-driven stimulus in the hardware path.

---
 rtl/pixel_row_feeder.sv | 145 ++++++++++++++
 tb/tb_pixel_row_feeder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_row_feeder.sv
// pixel_row_feeder: streams a grayscale frame from a synchronous-read pixel RAM into the filter,
// priming PRIME_LINES rows, releasing one row per filter interrupt, then flushing with zero rows.
module pixel_row_feeder #(
    parameter int IMG_WIDTH   = 512,
    parameter int IMG_HEIGHT  = 512,
    parameter int PRIME_LINES = 4,
    parameter int PAD_LINES   = 2,
    parameter int ADDR_W      = 18
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_data,
    output logic              o_data_valid,
    output logic [7:0]        o_data,
    input  logic              i_data_ready,
    input  logic              i_intr
);
    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int RW = $clog2(IMG_HEIGHT + PAD_LINES + 1);
    localparam logic [CW-1:0]     COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0]     COL_FULL   = CW'(IMG_WIDTH);
    localparam logic [RW-1:0]     PRIME_LAST = RW'(PRIME_LINES - 1);
    localparam logic [RW-1:0]     IMG_ROWS   = RW'(IMG_HEIGHT);
    localparam logic [RW-1:0]     ROW_LAST   = RW'(IMG_HEIGHT + PAD_LINES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, PRIME, WAIT, LINE, PAD_WAIT, PAD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d, col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [1:0]        tok_q, tok_d, cnt_q, cnt_d;
    logic [7:0]        f0_q, f0_d, f1_q, f1_d;
    logic              intr_q, inflight_q, done_q, done_d, busy_q, busy_d;
    logic              img, valid, hs, pop, last, rd_en, intr_edge, inc, consume;
    logic [1:0]        occ;

    always_comb begin
        img       = (state_q == PRIME) || (state_q == LINE);
        valid     = img ? (cnt_q != 2'd0) : (state_q == PAD);
        hs        = valid && i_data_ready;
        pop       = img && hs;
        last      = hs && (col_q == COL_LAST);
        occ       = cnt_q - {1'b0, pop};
        // occupancy is taken after this cycle's pop so a steady stream never bubbles
        rd_en     = img && (rd_cnt_q != COL_FULL) && (({1'b0, occ} + {2'b0, inflight_q}) < 3'd2);
        intr_edge = i_intr && !intr_q && (state_q != IDLE);
        state_d   = state_q;
        row_d     = row_q;
        col_d     = hs ? ((col_q == COL_LAST) ? '0 : col_q + 1'b1) : col_q;
        rd_cnt_d  = rd_cnt_q + CW'(rd_en);
        addr_d    = (rd_en && addr_q != ADDR_LAST) ? addr_q + 1'b1 : addr_q;
        consume   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: state_d = i_start ? PRIME : IDLE;
            PRIME: if (last) begin
                row_d    = row_q + 1'b1;
                rd_cnt_d = '0;
                state_d  = (row_q == PRIME_LAST) ? WAIT : PRIME;
            end
            WAIT: if (row_q >= IMG_ROWS) state_d = PAD_WAIT;
                  else if (tok_q != 2'd0) begin
                      state_d = LINE;
                      consume = 1'b1;
                  end
            LINE: if (last) begin
                row_d    = row_q + 1'b1;
                rd_cnt_d = '0;
                state_d  = WAIT;
            end
            PAD_WAIT: if (tok_q != 2'd0) begin
                state_d = PAD;
                consume = 1'b1;
            end
            PAD: if (last) begin
                row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                state_d = (row_q == ROW_LAST) ? IDLE : PAD_WAIT;
                done_d  = (row_q == ROW_LAST);
            end
            default: state_d = IDLE;
        endcase
        // same-cycle edge and consume cancel even when saturated
        inc   = intr_edge && (tok_q != 2'd3 || consume);
        tok_d = tok_q + {1'b0, inc} - {1'b0, consume};
        cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        f0_d  = pop ? ((cnt_q == 2'd2) ? f1_q : (inflight_q ? i_mem_data : f0_q))
                    : ((cnt_q == 2'd0 && inflight_q) ? i_mem_data : f0_q);
        f1_d  = (inflight_q && occ == 2'd1) ? i_mem_data : f1_q;
        if (state_q == IDLE && i_start) begin
            tok_d    = '0;
            addr_d   = '0;
            rd_cnt_d = '0;
            col_d    = '0;
            row_d    = '0;
            cnt_d    = '0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_cnt_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            tok_q      <= '0;
            cnt_q      <= '0;
            f0_q       <= '0;
            f1_q       <= '0;
            intr_q     <= 1'b0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_cnt_q   <= rd_cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            tok_q      <= tok_d;
            cnt_q      <= cnt_d;
            f0_q       <= f0_d;
            f1_q       <= f1_d;
            intr_q     <= i_intr;
            inflight_q <= rd_en;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_mem_rd_en  = rd_en;
    assign o_mem_addr   = addr_q;
    assign o_data_valid = valid;
    assign o_data       = (state_q == PAD) ? 8'd0 : f0_q;
endmodule

// File: tb/tb_pixel_row_feeder.sv
// tb_pixel_row_feeder: table-driven frame scenarios on an 8x6 image plus hand-written
// sequences for mid-frame reset and a held interrupt.
module tb_pixel_row_feeder;
    localparam int W = 8, H = 6, AW = 6;

    logic          axi_clk = 0, axi_reset_n = 0, i_start = 0, i_intr = 0, i_data_ready = 1;
    logic          rnd_mode = 0;
    logic          o_busy, o_done, o_mem_rd_en, o_data_valid;
    logic [AW-1:0] o_mem_addr;
    logic [7:0]    i_mem_data = 0, o_data, prev_data = 0;
    int            checks = 0, passed = 0;
    int            hs_cnt = 0, done_cnt = 0, stab_v = 0, gap_v = 0, bub_v = 0, addr_v = 0, busy_v = 0;
    bit            after_row = 0, prev_stall = 0;
    logic [7:0]    rx[$];

    typedef struct {
        bit rnd;
        int early;
        bit dbl;
        int exp_hs;
        int exp_done;
    } vec_t;
    vec_t vecs[5];

    always #5 axi_clk = ~axi_clk;

    pixel_row_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(4), .PAD_LINES(2), .ADDR_W(AW)) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .i_start(i_start), .o_busy(o_busy),
        .o_done(o_done), .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .o_data_valid(o_data_valid), .o_data(o_data), .i_data_ready(i_data_ready), .i_intr(i_intr)
    );

    always @(posedge axi_clk) if (o_mem_rd_en) i_mem_data <= 8'(o_mem_addr);

    always @(posedge axi_clk) begin
        #1;
        i_data_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge axi_clk) begin
        if (!axi_reset_n) begin
            prev_stall = 0;
            after_row  = 0;
        end else if (i_start && !o_busy) begin
            rx.delete();
            hs_cnt = 0; done_cnt = 0; stab_v = 0; gap_v = 0; bub_v = 0; addr_v = 0; busy_v = 0;
            after_row = 0; prev_stall = 0;
        end else begin
            if (prev_stall && (!o_data_valid || o_data != prev_data)) stab_v++;
            if (after_row && o_data_valid) gap_v++;
            if (hs_cnt % W != 0 && !o_data_valid) bub_v++;
            if (o_mem_rd_en && o_mem_addr > AW'(W * H - 1)) addr_v++;
            if (o_done) begin
                done_cnt++;
                if (o_busy) busy_v++;
            end
            after_row = 0;
            if (o_data_valid && i_data_ready) begin
                rx.push_back(o_data);
                hs_cnt++;
                if (hs_cnt % W == 0) after_row = 1;
            end
            prev_stall = o_data_valid && !i_data_ready;
            prev_data  = o_data;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge axi_clk);
        #1;
    endtask

    task automatic wait_hs(input int t);
        int n = 0;
        while (hs_cnt < t && n < 500) begin
            cyc(1);
            n++;
        end
        chk($sformatf("wait_hs_%0d", t), int'(hs_cnt >= t), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 500) begin
            cyc(1);
            n++;
        end
        chk("wait_done", int'(done_cnt > 0), 1);
        cyc(3);
    endtask

    task automatic pulse_start();
        i_start = 1;
        cyc(1);
        i_start = 0;
    endtask

    task automatic pulse_intr();
        i_intr = 1;
        cyc(1);
        i_intr = 0;
        cyc(2);
    endtask

    task automatic check_frame(input string tag, input int exp_hs, input int exp_done, input int idle_v);
        int bad = 0;
        for (int i = 0; i < rx.size(); i++)
            if (rx[i] != ((i < W * H) ? 8'(i) : 8'd0)) bad++;
        chk({tag, "_handshakes"}, hs_cnt, exp_hs);
        chk({tag, "_data_errors"}, bad, 0);
        chk({tag, "_done_pulses"}, done_cnt, exp_done);
        chk({tag, "_stall_unstable"}, stab_v, 0);
        chk({tag, "_row_gap_missing"}, gap_v, 0);
        chk({tag, "_mid_row_bubbles"}, bub_v, 0);
        chk({tag, "_addr_over_max"}, addr_v, 0);
        chk({tag, "_busy_at_done"}, busy_v, 0);
        chk({tag, "_ran_without_intr"}, idle_v, 0);
    endtask

    task automatic run_frame(input string tag, input bit rnd, input int early, input bit dbl,
                             input int exp_hs, input int exp_done);
        int idle_v = 0, h;
        rnd_mode = rnd;
        pulse_start();
        if (dbl) begin
            cyc(3);
            pulse_start();
        end
        cyc(1);
        repeat (early) pulse_intr();
        for (int k = 0; k < 4; k++) begin
            wait_hs(4 * W + W * k);
            if (k >= early) begin
                h = hs_cnt;
                cyc(6);
                if (hs_cnt != h) idle_v++;
                pulse_intr();
            end
        end
        wait_done();
        check_frame(tag, exp_hs, exp_done, idle_v);
        rnd_mode = 0;
    endtask

    initial begin
        int h;
        vecs[0] = '{rnd: 0, early: 0, dbl: 0, exp_hs: 64, exp_done: 1};
        vecs[1] = '{rnd: 1, early: 0, dbl: 0, exp_hs: 64, exp_done: 1};
        vecs[2] = '{rnd: 0, early: 3, dbl: 0, exp_hs: 64, exp_done: 1};
        vecs[3] = '{rnd: 0, early: 0, dbl: 1, exp_hs: 64, exp_done: 1};
        vecs[4] = '{rnd: 1, early: 3, dbl: 1, exp_hs: 64, exp_done: 1};
        cyc(3);
        axi_reset_n = 1;
        cyc(2);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_valid", o_data_valid, 0);
        chk("rst_rd_en", o_mem_rd_en, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_data", o_data, 0);
        for (int v = 0; v < 5; v++)
            run_frame($sformatf("vec%0d", v), vecs[v].rnd, vecs[v].early, vecs[v].dbl,
                      vecs[v].exp_hs, vecs[v].exp_done);

        pulse_start();
        cyc(1);
        pulse_intr();
        pulse_intr();
        wait_hs(20);
        axi_reset_n = 0;
        #1;
        chk("abort_rd_en", o_mem_rd_en, 0);
        chk("abort_valid", o_data_valid, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        chk("abort_addr", o_mem_addr, 0);
        chk("abort_data", o_data, 0);
        cyc(3);
        axi_reset_n = 1;
        cyc(2);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle_busy", o_busy, 0);
        run_frame("restart", 0, 0, 0, 64, 1);

        pulse_start();
        cyc(2);
        i_intr = 1;
        cyc(10);
        i_intr = 0;
        wait_hs(40);
        h = hs_cnt;
        cyc(15);
        chk("hold_one_token", hs_cnt, h);
        chk("hold_rows_sent", hs_cnt, 40);
        pulse_intr();
        wait_hs(48);
        pulse_intr();
        wait_hs(56);
        pulse_intr();
        wait_done();
        check_frame("hold", 64, 1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
